// File: rtl/jump_sequencer_if.sv
// jump_sequencer_if: pipeline-control handshake and statistics bundle for jump_sequencer
interface jump_sequencer_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   jump_start;
    logic                   take_branch;
    logic                   want_stall;
    logic                   flush;
    logic [1:0]             branch_status;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] jump_count;
    logic [COUNT_WIDTH-1:0] taken_count;

    modport master (
        output jump_start, take_branch, want_stall, flush,
        input  branch_status, busy, jump_count, taken_count
    );

    modport slave (
        input  jump_start, take_branch, want_stall, flush,
        output branch_status, busy, jump_count, taken_count
    );
endinterface

// File: rtl/jump_sequencer.sv
// jump_sequencer: sequences a control-transfer through WAIT/RESOLVE/RELEASE and counts resolves
module jump_sequencer #(
    parameter int RESOLVE_DELAY = 2,
    parameter int COUNT_WIDTH   = 32
) (
    input logic             clock,
    input logic             reset,
    jump_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESOLVE, RELEASE} state_t;

    state_t                 state, state_n;
    logic [2:0]             cnt, cnt_n;
    logic                   count_en;
    logic [COUNT_WIDTH-1:0] jump_count, taken_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // WAIT is entered with RESOLVE_DELAY-1 and leaves as the count runs out,
    // so RESOLVE lands exactly RESOLVE_DELAY cycles after acceptance
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        count_en = 1'b0;
        if (bus.flush) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (!bus.want_stall) begin
            case (state)
                IDLE: if (bus.jump_start) begin
                    state_n = (RESOLVE_DELAY == 1) ? RESOLVE : WAIT;
                    cnt_n   = 3'(RESOLVE_DELAY - 1);
                end
                WAIT: begin
                    state_n = (cnt == 3'd1) ? RESOLVE : WAIT;
                    cnt_n   = cnt - 3'd1;
                end
                RESOLVE: begin
                    state_n  = RELEASE;
                    count_en = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jump_count  <= '0;
            taken_count <= '0;
        end else if (count_en) begin
            if (!(&jump_count))
                jump_count <= jump_count + COUNT_WIDTH'(1);
            if (bus.take_branch && !(&taken_count))
                taken_count <= taken_count + COUNT_WIDTH'(1);
        end
    end

    assign bus.branch_status = (state == RESOLVE) ? 2'b01 : (state == RELEASE) ? 2'b10 : 2'b00;
    assign bus.busy          = (state != IDLE);
    assign bus.jump_count    = jump_count;
    assign bus.taken_count   = taken_count;
endmodule

// File: tb/tb_jump_sequencer.sv
// tb_jump_sequencer: directed scoreboard bench for jump_sequencer (delay 2 / width 4, and delay 1 / width 32)
module tb_jump_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    jump_sequencer_if #(.COUNT_WIDTH(4))  b0();
    jump_sequencer_if #(.COUNT_WIDTH(32)) b1();

    jump_sequencer #(.RESOLVE_DELAY(2), .COUNT_WIDTH(4))  u0 (.clock(clock), .reset(reset), .bus(b0));
    jump_sequencer #(.RESOLVE_DELAY(1), .COUNT_WIDTH(32)) u1 (.clock(clock), .reset(reset), .bus(b1));

    typedef struct {
        int         s;
        logic [1:0] st;
        logic       b;
        int         jc;
        int         tc;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic drive(input int s, input logic js, tk, sl, fl);
        b0.jump_start  = (s == 0) && js;
        b0.take_branch = (s == 0) && tk;
        b0.want_stall  = (s == 0) && sl;
        b0.flush       = (s == 0) && fl;
        b1.jump_start  = (s == 1) && js;
        b1.take_branch = (s == 1) && tk;
        b1.want_stall  = (s == 1) && sl;
        b1.flush       = (s == 1) && fl;
    endtask

    task automatic expect_now(input int s, input logic [1:0] es, input logic eb, input int jc, tc, input string nm);
        exp_t e;
        e.s = s; e.st = es; e.b = eb; e.jc = jc; e.tc = tc; e.nm = nm;
        q.push_back(e);
    endtask

    // one cycle: apply inputs, record the outputs expected during this cycle
    task automatic step(input int s, input logic js, tk, sl, fl,
                        input logic [1:0] es, input logic eb, input int jc, tc, input string nm);
        drive(s, js, tk, sl, fl);
        expect_now(s, es, eb, jc, tc, nm);
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input string f, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s %s actual %0d required %0d", nm, f, act, req);
        end
    endtask

    exp_t       m_e;
    logic [1:0] m_st;
    logic       m_b;
    int         m_jc, m_tc;

    always @(negedge clock) begin
        if (q.size() != 0) begin
            m_e  = q.pop_front();
            m_st = (m_e.s == 0) ? b0.branch_status : b1.branch_status;
            m_b  = (m_e.s == 0) ? b0.busy : b1.busy;
            m_jc = (m_e.s == 0) ? int'(b0.jump_count) : int'(b1.jump_count);
            m_tc = (m_e.s == 0) ? int'(b0.taken_count) : int'(b1.taken_count);
            chk(m_e.nm, "status", int'(m_st), int'(m_e.st));
            chk(m_e.nm, "busy", int'(m_b), int'(m_e.b));
            chk(m_e.nm, "jump_count", m_jc, m_e.jc);
            chk(m_e.nm, "taken_count", m_tc, m_e.tc);
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        expect_now(0, 2'b00, 1'b0, 0, 0, "reset_u0");
        @(posedge clock); #1;
        expect_now(1, 2'b00, 1'b0, 0, 0, "reset_u1");
        @(posedge clock); #1;
        reset = 1'b0;
        // basic jump, delay 2, taken; jump_start ignored outside IDLE
        step(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, "a_c0");
        step(0, 1, 0, 0, 0, 2'b00, 1, 0, 0, "a_c1_wait");
        step(0, 1, 1, 0, 0, 2'b01, 1, 0, 0, "a_c2_resolve");
        step(0, 1, 0, 0, 0, 2'b10, 1, 1, 1, "a_c3_release");
        step(0, 0, 0, 0, 0, 2'b00, 0, 1, 1, "a_c4_idle");
        // stalls in WAIT, not taken
        step(0, 1, 0, 0, 0, 2'b00, 0, 1, 1, "b_c0");
        step(0, 0, 0, 1, 0, 2'b00, 1, 1, 1, "b_c1_stall");
        step(0, 0, 0, 1, 0, 2'b00, 1, 1, 1, "b_c2_stall");
        step(0, 0, 0, 0, 0, 2'b00, 1, 1, 1, "b_c3_wait");
        step(0, 0, 0, 0, 0, 2'b01, 1, 1, 1, "b_c4_resolve");
        step(0, 0, 0, 0, 0, 2'b10, 1, 2, 1, "b_c5_release");
        step(0, 0, 0, 0, 0, 2'b00, 0, 2, 1, "b_c6_idle");
        // stalled request in IDLE is not accepted
        step(0, 1, 0, 1, 0, 2'b00, 0, 2, 1, "c_stall_req");
        step(0, 0, 0, 0, 0, 2'b00, 0, 2, 1, "c_not_accepted");
        // stalls in RESOLVE and RELEASE, then back-to-back accept
        step(0, 1, 0, 0, 0, 2'b00, 0, 2, 1, "d_c0");
        step(0, 0, 0, 0, 0, 2'b00, 1, 2, 1, "d_wait");
        step(0, 0, 1, 1, 0, 2'b01, 1, 2, 1, "d_resolve_stall");
        step(0, 0, 0, 0, 0, 2'b01, 1, 2, 1, "d_resolve");
        step(0, 0, 0, 1, 0, 2'b10, 1, 3, 1, "d_release_stall");
        step(0, 0, 0, 0, 0, 2'b10, 1, 3, 1, "d_release");
        step(0, 1, 0, 0, 0, 2'b00, 0, 3, 1, "d_b2b_accept");
        // flush in WAIT, flush with jump_start in IDLE, flush in RESOLVE and RELEASE
        step(0, 0, 0, 1, 1, 2'b00, 1, 3, 1, "e_wait_flush");
        step(0, 1, 0, 0, 1, 2'b00, 0, 3, 1, "e_idle_flush_js");
        step(0, 1, 0, 0, 0, 2'b00, 0, 3, 1, "e_still_idle");
        step(0, 0, 0, 0, 0, 2'b00, 1, 3, 1, "e_wait");
        step(0, 0, 1, 0, 1, 2'b01, 1, 3, 1, "e_resolve_flush");
        step(0, 0, 0, 0, 0, 2'b00, 0, 3, 1, "e_after_flush");
        step(0, 1, 0, 0, 0, 2'b00, 0, 3, 1, "e_c0");
        step(0, 0, 0, 0, 0, 2'b00, 1, 3, 1, "e_wait2");
        step(0, 0, 1, 0, 0, 2'b01, 1, 3, 1, "e_resolve2");
        step(0, 0, 0, 0, 1, 2'b10, 1, 4, 2, "e_release_flush");
        step(0, 0, 0, 0, 0, 2'b00, 0, 4, 2, "e_idle");
        // delay 1 with jump_start held high
        step(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, "f_c0");
        step(1, 1, 1, 0, 0, 2'b01, 1, 0, 0, "f_c1");
        step(1, 1, 1, 0, 0, 2'b10, 1, 1, 1, "f_c2");
        step(1, 1, 1, 0, 0, 2'b00, 0, 1, 1, "f_c3_accept");
        step(1, 1, 1, 0, 0, 2'b01, 1, 1, 1, "f_c4");
        step(1, 1, 1, 0, 0, 2'b10, 1, 2, 2, "f_c5");
        step(1, 0, 0, 0, 0, 2'b00, 0, 2, 2, "f_c6");
        // asynchronous reset pulse between edges while in WAIT
        step(0, 1, 0, 0, 0, 2'b00, 0, 4, 2, "g_accept");
        drive(0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        expect_now(0, 2'b00, 0, 0, 0, "g_async_reset");
        @(posedge clock); #1;
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, "g_u1_cleared");
        // saturation at 15 for a 4-bit counter; first iteration is the first accept after reset
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0, 0, 2'b00, 0, i, i, "h_idle");
            step(0, 0, 0, 0, 0, 2'b00, 1, i, i, "h_wait");
            step(0, 0, 1, 0, 0, 2'b01, 1, i, i, "h_resolve");
            step(0, 0, 0, 0, 0, 2'b10, 1, (i == 15) ? 15 : i + 1, (i == 15) ? 15 : i + 1, "h_release");
        end
        step(0, 0, 0, 0, 0, 2'b00, 0, 15, 15, "h_saturated");
        repeat (2) @(negedge clock);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending actual %0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
